// File: rtl/tcdm_mem_model.sv
// Multi-port TCDM memory model for accelerator benches: NP 32-bit ports on one
// word array, programmable read latency, LFSR-driven grant stalls, per-port
// traffic counters and an end-of-computation mailbox.
module tcdm_mem_model #(
   parameter int unsigned NP           = 9,
   parameter int unsigned MEM_WORDS    = 49152,
   parameter logic [31:0] BASE_ADDR    = 32'h1c010000,
   parameter int unsigned RLAT         = 1,
   parameter logic [7:0]  STALL_THRESH = 8'd0,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [31:0] EOC_ADDR     = 32'h80000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NP-1:0]     tcdm_req_i,
   output logic [NP-1:0]     tcdm_gnt_o,
   input  logic [NP*32-1:0]  tcdm_add_i,
   input  logic [NP-1:0]     tcdm_wen_i,
   input  logic [NP*4-1:0]   tcdm_be_i,
   input  logic [NP*32-1:0]  tcdm_data_i,
   output logic [NP*32-1:0]  tcdm_r_data_o,
   output logic [NP-1:0]     tcdm_r_valid_o,
   input  logic              stall_en_i,
   input  logic              clear_cnt_i,
   output logic              eoc_o,
   output logic [31:0]       eoc_data_o,
   output logic [NP*32-1:0]  cnt_rd_o,
   output logic [NP*32-1:0]  cnt_wr_o,
   output logic [15:0]       oor_cnt_o
);

   localparam int unsigned AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   // Clamped copy of RLAT used only for sizing, so a bad RLAT reports cleanly.
   localparam int unsigned LAT = (RLAT < 1) ? 1 : ((RLAT > 4) ? 4 : RLAT);
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

   if (RLAT < 1 || RLAT > 4) begin : g_rlat_check
      $fatal(1, "tcdm_mem_model: RLAT must be in 1..4");
   end

   function automatic logic [15:0] seed_of(input int unsigned p);
      logic [15:0] s;
      s = LFSR_SEED ^ 16'(p);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   // Storage and state
   logic [31:0]    mem_q [MEM_WORDS];
   logic [15:0]    lfsr_q [NP];
   logic [15:0]    lfsr_d [NP];
   logic [LAT-1:0] vld_q [NP];
   logic [31:0]    dat_q [NP][LAT];
   logic [31:0]    cnt_rd_q [NP];
   logic [31:0]    cnt_rd_d [NP];
   logic [31:0]    cnt_wr_q [NP];
   logic [31:0]    cnt_wr_d [NP];
   logic [15:0]    oor_cnt_q, oor_cnt_d;
   logic           eoc_q, eoc_d;
   logic [31:0]    eoc_data_q, eoc_data_d;

   // Per-port decode
   logic [31:0]    add [NP];
   logic [31:0]    wdata [NP];
   logic [3:0]     be [NP];
   logic [AW-1:0]  widx [NP];
   logic [31:0]    rdata [NP];
   logic [NP-1:0]  in_range, is_eoc, stall, lost, gnt, mem_wr_req;

   // Unpack ports, decode addresses and evaluate stall conditions.
   // NOTE: every variable an always_comb writes gets a value up front on every
   // path; a variable left unassigned on some path becomes an inferred latch.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         add[p]        = tcdm_add_i[p*32 +: 32];
         wdata[p]      = tcdm_data_i[p*32 +: 32];
         be[p]         = tcdm_be_i[p*4 +: 4];
         in_range[p]   = ({1'b0, add[p]} >= {1'b0, BASE_ADDR}) && ({1'b0, add[p]} < END_ADDR);
         is_eoc[p]     = (add[p] == EOC_ADDR);
         widx[p]       = AW'((add[p] - BASE_ADDR) >> 2);
         stall[p]      = stall_en_i && (lfsr_q[p][7:0] < STALL_THRESH);
         mem_wr_req[p] = tcdm_req_i[p] && !tcdm_wen_i[p] && in_range[p] && !is_eoc[p];
      end
   end

   // Same-word write conflicts: the lowest-index unstalled writer wins, reads never lose.
   always_comb begin
      lost = '0;
      for (int p = 1; p < NP; p++) begin
         for (int q = 0; q < p; q++) begin
            if (mem_wr_req[p] && mem_wr_req[q] && !stall[q] && (widx[q] == widx[p])) begin
               lost[p] = 1'b1;
            end
         end
      end
   end

   assign gnt        = tcdm_req_i & ~{NP{rst_i}} & ~stall & ~lost;
   assign tcdm_gnt_o = gnt;

   // Read data captured in the grant cycle; the array still holds pre-write data here.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         rdata[p] = 32'h0;
         if (tcdm_wen_i[p]) begin
            if (is_eoc[p]) begin
               rdata[p] = {31'b0, eoc_q};
            end else if (in_range[p]) begin
               rdata[p] = mem_q[widx[p]];
            end else begin
               rdata[p] = 32'hDEADBEEF;
            end
         end
      end
   end

   // Per-port Fibonacci LFSR step, taps x^16 + x^14 + x^13 + x^11.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         lfsr_d[p] = {lfsr_q[p][14:0], lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
      end
   end

   // LFSR state: reseeded on reset, free-running otherwise.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NP; p++) begin
         if (rst_i) begin
            lfsr_q[p] <= seed_of(p);
         end else begin
            lfsr_q[p] <= lfsr_d[p];
         end
      end
   end

   // Word array updates for granted in-range writes, byte-enabled.
   // NOTE: the array is deliberately not reset, so bench preload survives a
   // mid-run reset and no reset fan-out reaches the storage.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NP; p++) begin
         if (gnt[p] && mem_wr_req[p]) begin
            for (int b = 0; b < 4; b++) begin
               if (be[p][b]) begin
                  mem_q[widx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
               end
            end
         end
      end
   end

   // Response pipeline: LAT-deep shift per port, one entry per granted access.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NP; p++) begin
         if (rst_i) begin
            vld_q[p] <= '0;
            for (int s = 0; s < LAT; s++) begin
               dat_q[p][s] <= 32'h0;
            end
         end else begin
            vld_q[p][0] <= gnt[p];
            dat_q[p][0] <= rdata[p];
            for (int s = 1; s < LAT; s++) begin
               vld_q[p][s] <= vld_q[p][s-1];
               dat_q[p][s] <= dat_q[p][s-1];
            end
         end
      end
   end

   // Next state for the mailbox and the saturating traffic counters.
   always_comb begin
      logic [16:0] oor_inc;
      logic [16:0] oor_sum;
      eoc_d      = eoc_q;
      eoc_data_d = eoc_data_q;
      oor_inc    = 17'd0;
      // Walk downwards so the lowest-index mailbox writer is the last assignment.
      for (int p = NP - 1; p >= 0; p--) begin
         if (gnt[p] && !tcdm_wen_i[p] && is_eoc[p]) begin
            eoc_d = 1'b1;
            if (!eoc_q) begin
               eoc_data_d = wdata[p];
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         cnt_rd_d[p] = cnt_rd_q[p];
         cnt_wr_d[p] = cnt_wr_q[p];
         if (gnt[p]) begin
            if (tcdm_wen_i[p]) begin
               if (cnt_rd_q[p] != 32'hFFFFFFFF) cnt_rd_d[p] = cnt_rd_q[p] + 32'd1;
            end else begin
               if (cnt_wr_q[p] != 32'hFFFFFFFF) cnt_wr_d[p] = cnt_wr_q[p] + 32'd1;
            end
            if (!in_range[p] && !is_eoc[p]) oor_inc = oor_inc + 17'd1;
         end
         if (clear_cnt_i) begin
            cnt_rd_d[p] = 32'h0;
            cnt_wr_d[p] = 32'h0;
         end
      end
      oor_sum   = {1'b0, oor_cnt_q} + oor_inc;
      oor_cnt_d = oor_sum[16] ? 16'hFFFF : oor_sum[15:0];
      if (clear_cnt_i) oor_cnt_d = 16'h0;
   end

   // Mailbox and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         eoc_q      <= 1'b0;
         eoc_data_q <= 32'h0;
         oor_cnt_q  <= 16'h0;
         for (int p = 0; p < NP; p++) begin
            cnt_rd_q[p] <= 32'h0;
            cnt_wr_q[p] <= 32'h0;
         end
      end else begin
         eoc_q      <= eoc_d;
         eoc_data_q <= eoc_data_d;
         oor_cnt_q  <= oor_cnt_d;
         for (int p = 0; p < NP; p++) begin
            cnt_rd_q[p] <= cnt_rd_d[p];
            cnt_wr_q[p] <= cnt_wr_d[p];
         end
      end
   end

   // Output packing.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         tcdm_r_valid_o[p]         = vld_q[p][LAT-1];
         tcdm_r_data_o[p*32 +: 32] = dat_q[p][LAT-1];
         cnt_rd_o[p*32 +: 32]      = cnt_rd_q[p];
         cnt_wr_o[p*32 +: 32]      = cnt_wr_q[p];
      end
   end

   assign eoc_o      = eoc_q;
   assign eoc_data_o = eoc_data_q;
   assign oor_cnt_o  = oor_cnt_q;

   // Protocol monitor state: what each port presented while waiting for a grant.
   logic [NP-1:0] pend_q;
   logic [NP-1:0] pend_wen_q;
   logic [31:0]   pend_add_q [NP];
   logic [31:0]   pend_data_q [NP];

   // Remember ungranted requests so the next cycle can confirm they were held.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= tcdm_req_i & ~gnt;
      end
      pend_wen_q <= tcdm_wen_i;
      for (int p = 0; p < NP; p++) begin
         pend_add_q[p]  <= add[p];
         pend_data_q[p] <= wdata[p];
      end
   end

   // Warn when a pending request is dropped or altered before its grant
   // (write data only matters for writes).
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int p = 0; p < NP; p++) begin
            if (pend_q[p]) begin
               assert (tcdm_req_i[p] && (add[p] == pend_add_q[p]) && (tcdm_wen_i[p] == pend_wen_q[p])
                       && (pend_wen_q[p] || (wdata[p] == pend_data_q[p])))
               else $warning("tcdm_mem_model: port %0d changed a pending request", p);
            end
         end
      end
   end

endmodule

// File: tb/tb_tcdm_mem_model.sv
// Directed bench for tcdm_mem_model. Three instances share one stimulus bus:
// u0 RLAT=1 with STALL_THRESH=128, u1 RLAT=3, u2 RLAT=2 (both never stall).
module tb_tcdm_mem_model;

   localparam int          NP   = 9;
   localparam int          MW   = 1024;
   localparam logic [31:0] BASE = 32'h1c010000;
   localparam logic [31:0] EOCA = 32'h80000000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     req, wen;
   logic [NP*32-1:0]  add, wdata;
   logic [NP*4-1:0]   be;
   logic              stall_en, clear_cnt;

   logic [NP-1:0]     gnt [3];
   logic [NP-1:0]     rvld [3];
   logic [NP*32-1:0]  rdata [3];
   logic [NP*32-1:0]  cnt_rd [3];
   logic [NP*32-1:0]  cnt_wr [3];
   logic              eoc [3];
   logic [31:0]       eoc_data [3];
   logic [15:0]       oor [3];

   int checks = 0;
   int errors = 0;
   bit cur_seq[$];

   always #5 clk = ~clk;

   tcdm_mem_model #(.NP(NP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .RLAT(1), .STALL_THRESH(8'd128),
                    .LFSR_SEED(16'hACE1), .EOC_ADDR(EOCA)) u0 (
      .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_gnt_o(gnt[0]), .tcdm_add_i(add),
      .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata[0]),
      .tcdm_r_valid_o(rvld[0]), .stall_en_i(stall_en), .clear_cnt_i(clear_cnt), .eoc_o(eoc[0]),
      .eoc_data_o(eoc_data[0]), .cnt_rd_o(cnt_rd[0]), .cnt_wr_o(cnt_wr[0]), .oor_cnt_o(oor[0]));

   tcdm_mem_model #(.NP(NP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .RLAT(3), .STALL_THRESH(8'd0),
                    .LFSR_SEED(16'hACE1), .EOC_ADDR(EOCA)) u1 (
      .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_gnt_o(gnt[1]), .tcdm_add_i(add),
      .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata[1]),
      .tcdm_r_valid_o(rvld[1]), .stall_en_i(stall_en), .clear_cnt_i(clear_cnt), .eoc_o(eoc[1]),
      .eoc_data_o(eoc_data[1]), .cnt_rd_o(cnt_rd[1]), .cnt_wr_o(cnt_wr[1]), .oor_cnt_o(oor[1]));

   tcdm_mem_model #(.NP(NP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .RLAT(2), .STALL_THRESH(8'd0),
                    .LFSR_SEED(16'hACE1), .EOC_ADDR(EOCA)) u2 (
      .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_gnt_o(gnt[2]), .tcdm_add_i(add),
      .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata[2]),
      .tcdm_r_valid_o(rvld[2]), .stall_en_i(stall_en), .clear_cnt_i(clear_cnt), .eoc_o(eoc[2]),
      .eoc_data_o(eoc_data[2]), .cnt_rd_o(cnt_rd[2]), .cnt_wr_o(cnt_wr[2]), .oor_cnt_o(oor[2]));

   function automatic logic [31:0] word(input logic [NP*32-1:0] v, input int p);
      return v[p*32 +: 32];
   endfunction

   task automatic drive(input int p, input logic w_n, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      req[p] = 1'b1;
      wen[p] = w_n;
      add[p*32 +: 32] = a;
      be[p*4 +: 4] = b;
      wdata[p*32 +: 32] = d;
   endtask

   task automatic idle();
      req = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 1'b1, BASE, 4'hF, 32'h0);
      repeat (3) step();
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (gnt[u] !== '0) begin errors++; $display("FAIL reset_gnt u%0d: got %h expected 0", u, gnt[u]); end
         checks++;
         if (rvld[u] !== '0 || rdata[u] !== '0) begin errors++; $display("FAIL reset_resp u%0d: got %h/%h expected 0", u, rvld[u], rdata[u]); end
         checks++;
         if (eoc[u] !== 1'b0 || eoc_data[u] !== 32'h0 || oor[u] !== 16'h0) begin
            errors++; $display("FAIL reset_eoc u%0d: got %b/%h/%h expected 0", u, eoc[u], eoc_data[u], oor[u]);
         end
         checks++;
         if (cnt_rd[u] !== '0 || cnt_wr[u] !== '0) begin errors++; $display("FAIL reset_cnt u%0d: got nonzero counters expected 0", u); end
      end
      step();
      rst = 1'b0;
      idle();
   endtask

   task automatic test_basic();
      logic [31:0] a = 32'h1c010010;
      clear_cnt = 1'b1;
      drive(0, 1'b0, a, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt[0][0] !== 1'b1) begin errors++; $display("FAIL basic_gnt_preload: got %b expected 1", gnt[0][0]); end
      step();
      clear_cnt = 1'b0;
      drive(0, 1'b0, a, 4'h3, 32'h12345678);
      @(negedge clk);
      checks++;
      if (gnt[0][0] !== 1'b1) begin errors++; $display("FAIL basic_gnt_wr: got %b expected 1", gnt[0][0]); end
      checks++;
      if (rvld[0][0] !== 1'b1 || word(rdata[0], 0) !== 32'h0) begin
         errors++; $display("FAIL basic_wr_resp: got %b/%h expected 1/00000000", rvld[0][0], word(rdata[0], 0));
      end
      step();
      drive(0, 1'b1, a, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt[0][0] !== 1'b1) begin errors++; $display("FAIL basic_gnt_rd: got %b expected 1", gnt[0][0]); end
      step();
      idle();
      @(negedge clk);
      checks++;
      if (rvld[0][0] !== 1'b1 || word(rdata[0], 0) !== 32'h00005678) begin
         errors++; $display("FAIL basic_rd_data: got %b/%h expected 1/00005678", rvld[0][0], word(rdata[0], 0));
      end
      step();
      @(negedge clk);
      checks++;
      if (rvld[0][0] !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", rvld[0][0]); end
      checks++;
      if (word(cnt_wr[0], 0) !== 32'd1 || word(cnt_rd[0], 0) !== 32'd1) begin
         errors++; $display("FAIL basic_cnt: got wr %0d rd %0d expected 1/1", word(cnt_wr[0], 0), word(cnt_rd[0], 0));
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      for (int i = 0; i < 4; i++) begin
         drive(2, 1'b0, BASE + 32'(4 * i), 4'hF, 32'hC0DE0000 | 32'(i));
         step();
      end
      idle();
      repeat (4) step();
      for (int k = 0; k < 10; k++) begin
         if (k < 4) drive(2, 1'b1, BASE + 32'(4 * k), 4'hF, 32'h0);
         else idle();
         @(negedge clk);
         if (k < 4) begin
            checks++;
            if (gnt[1][2] !== 1'b1) begin errors++; $display("FAIL b2b_gnt k%0d: got %b expected 1", k, gnt[1][2]); end
         end
         exp_v = (k >= 3 && k <= 6);
         checks++;
         if (rvld[1][2] !== exp_v || (exp_v && word(rdata[1], 2) !== (32'hC0DE0000 | 32'(k - 3)))) begin
            errors++;
            $display("FAIL b2b_resp k%0d: got %b/%h expected %b/%h", k, rvld[1][2], word(rdata[1], 2),
                     exp_v, 32'hC0DE0000 | 32'(k - 3));
         end
         step();
      end
   endtask

   task automatic test_conflict();
      logic [31:0] a = BASE + 32'h20;
      drive(0, 1'b0, a, 4'hF, 32'h0);
      step();
      idle();
      drive(1, 1'b0, a, 4'hF, 32'hAAAA0001);
      drive(4, 1'b0, a, 4'hF, 32'hBBBB0004);
      drive(5, 1'b1, a, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt[0] !== 9'h022) begin errors++; $display("FAIL conflict_gnt1: got %h expected 022", gnt[0]); end
      step();
      req[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt[0] !== 9'h030) begin errors++; $display("FAIL conflict_gnt2: got %h expected 030", gnt[0]); end
      checks++;
      if (rvld[0][5] !== 1'b1 || word(rdata[0], 5) !== 32'h0) begin
         errors++; $display("FAIL conflict_old: got %b/%h expected 1/00000000", rvld[0][5], word(rdata[0], 5));
      end
      step();
      idle();
      @(negedge clk);
      checks++;
      if (rvld[0][5] !== 1'b1 || word(rdata[0], 5) !== 32'hAAAA0001) begin
         errors++; $display("FAIL conflict_mid: got %b/%h expected 1/aaaa0001", rvld[0][5], word(rdata[0], 5));
      end
      step();
      drive(0, 1'b1, a, 4'hF, 32'h0);
      step();
      idle();
      @(negedge clk);
      checks++;
      if (rvld[0][0] !== 1'b1 || word(rdata[0], 0) !== 32'hBBBB0004) begin
         errors++; $display("FAIL conflict_final: got %b/%h expected 1/bbbb0004", rvld[0][0], word(rdata[0], 0));
      end
      step();
   endtask

   task automatic stall_run(input logic en, output int ncyc, output int ngnt);
      rst = 1'b1;
      stall_en = 1'b0;
      idle();
      step();
      rst = 1'b0;
      stall_en = en;
      cur_seq.delete();
      ncyc = 0;
      ngnt = 0;
      drive(0, 1'b1, BASE, 4'hF, 32'h0);
      while (ngnt < 1000 && ncyc < 5000) begin
         @(negedge clk);
         cur_seq.push_back(gnt[0][0]);
         if (gnt[0][0]) ngnt++;
         ncyc++;
         step();
      end
      idle();
      stall_en = 1'b0;
   endtask

   task automatic test_stall();
      int c1, g1, c2, g2, c3, g3, diffs;
      bit seq1[$];
      stall_run(1'b1, c1, g1);
      seq1 = cur_seq;
      checks++;
      if (g1 != 1000) begin errors++; $display("FAIL stall_all_granted: got %0d grants expected 1000", g1); end
      checks++;
      if (c1 <= 1000) begin errors++; $display("FAIL stall_seen: got %0d cycles expected more than 1000", c1); end
      stall_run(1'b1, c2, g2);
      diffs = 0;
      for (int i = 0; i < cur_seq.size() && i < seq1.size(); i++) if (cur_seq[i] != seq1[i]) diffs++;
      checks++;
      if (c2 != c1 || diffs != 0) begin
         errors++; $display("FAIL stall_repeat: got %0d cycles %0d diffs expected %0d cycles 0 diffs", c2, diffs, c1);
      end
      stall_run(1'b0, c3, g3);
      checks++;
      if (g3 != 1000 || c3 != 1000) begin errors++; $display("FAIL nostall_rate: got %0d/%0d expected 1000/1000", g3, c3); end
      checks++;
      if (word(cnt_rd[0], 0) !== 32'd1000) begin errors++; $display("FAIL stall_cnt_rd: got %0d expected 1000", word(cnt_rd[0], 0)); end
   endtask

   task automatic test_eoc();
      clear_cnt = 1'b1;
      idle();
      step();
      clear_cnt = 1'b0;
      drive(3, 1'b0, EOCA, 4'hF, 32'h1);
      drive(6, 1'b0, EOCA, 4'hF, 32'h1);
      @(negedge clk);
      checks++;
      if (gnt[0] !== 9'h048 || eoc[0] !== 1'b0) begin
         errors++; $display("FAIL eoc_gnt: got %h/%b expected 048/0", gnt[0], eoc[0]);
      end
      step();
      idle();
      drive(6, 1'b0, EOCA, 4'hF, 32'h2);
      @(negedge clk);
      checks++;
      if (eoc[0] !== 1'b1 || eoc_data[0] !== 32'h1) begin
         errors++; $display("FAIL eoc_rise: got %b/%h expected 1/00000001", eoc[0], eoc_data[0]);
      end
      step();
      idle();
      drive(0, 1'b1, EOCA, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (eoc_data[0] !== 32'h1 || oor[0] !== 16'h0) begin
         errors++; $display("FAIL eoc_first_only: got %h/%h expected 00000001/0000", eoc_data[0], oor[0]);
      end
      step();
      drive(0, 1'b1, BASE, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (rvld[0][0] !== 1'b1 || word(rdata[0], 0) !== 32'h1) begin
         errors++; $display("FAIL eoc_read: got %b/%h expected 1/00000001", rvld[0][0], word(rdata[0], 0));
      end
      step();
      idle();
      @(negedge clk);
      checks++;
      if (word(rdata[0], 0) !== 32'hC0DE0000) begin
         errors++; $display("FAIL eoc_mem_intact: got %h expected c0de0000", word(rdata[0], 0));
      end
      checks++;
      if (word(cnt_wr[0], 3) !== 32'd1 || word(cnt_wr[0], 6) !== 32'd2 || word(cnt_rd[0], 0) !== 32'd2 || oor[0] !== 16'h0) begin
         errors++; $display("FAIL eoc_cnt: got wr3 %0d wr6 %0d rd0 %0d oor %0d expected 1 2 2 0",
                            word(cnt_wr[0], 3), word(cnt_wr[0], 6), word(cnt_rd[0], 0), oor[0]);
      end
      step();
   endtask

   task automatic test_oor_reset();
      clear_cnt = 1'b1;
      idle();
      step();
      clear_cnt = 1'b0;
      drive(0, 1'b1, 32'h00000100, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt[0][0] !== 1'b1) begin errors++; $display("FAIL oor_gnt: got %b expected 1", gnt[0][0]); end
      step();
      idle();
      @(negedge clk);
      checks++;
      if (rvld[0][0] !== 1'b1 || word(rdata[0], 0) !== 32'hDEADBEEF || oor[0] !== 16'd1) begin
         errors++; $display("FAIL oor_read: got %b/%h/%0d expected 1/deadbeef/1", rvld[0][0], word(rdata[0], 0), oor[0]);
      end
      step();
      drive(0, 1'b1, BASE, 4'hF, 32'h0);
      step();
      rst = 1'b1;
      idle();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (rvld[2] !== '0) begin errors++; $display("FAIL reset_flush k%0d: got %h expected 0", k, rvld[2]); end
         step();
         if (k == 1) rst = 1'b0;
      end
      checks++;
      if (cnt_rd[2] !== '0 || cnt_wr[2] !== '0 || oor[0] !== 16'h0 || eoc[0] !== 1'b0 || eoc[2] !== 1'b0) begin
         errors++; $display("FAIL reset_clear: got oor %0d eoc %b/%b expected 0 0/0 with zero counters", oor[0], eoc[0], eoc[2]);
      end
      drive(0, 1'b1, BASE, 4'hF, 32'h0);
      step();
      idle();
      step();
      @(negedge clk);
      checks++;
      if (rvld[2][0] !== 1'b1 || word(rdata[2], 0) !== 32'hC0DE0000) begin
         errors++; $display("FAIL reset_mem_kept: got %b/%h expected 1/c0de0000", rvld[2][0], word(rdata[2], 0));
      end
      step();
      drive(2, 1'b0, EOCA, 4'hF, 32'h22);
      drive(7, 1'b0, EOCA, 4'hF, 32'h77);
      step();
      idle();
      @(negedge clk);
      checks++;
      if (eoc[0] !== 1'b1 || eoc_data[0] !== 32'h22) begin
         errors++; $display("FAIL eoc_priority: got %b/%h expected 1/00000022", eoc[0], eoc_data[0]);
      end
      step();
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      wen = '1;
      add = '0;
      wdata = '0;
      be = '0;
      stall_en = 1'b0;
      clear_cnt = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_conflict();
      test_stall();
      test_eoc();
      test_oor_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tcdm_mem_model.md
Name: tcdm_mem_model

Overview:
Parametrised multi-port TCDM memory model for accelerator benches, replacing per-bench dummy memories. It serves NP 32-bit TCDM ports onto one word array and supports:
- programmable read latency;
- deterministic LFSR-based grant stalling;
- per-port read/write counters;
- end-of-computation (EOC) mailbox detection, so the bench need not snoop core buses.

Parameters:
NP, 9, number of TCDM ports
MEM_WORDS, 49152, array depth in 32-bit words
BASE_ADDR, 32'h1c010000, byte address of word 0
RLAT, 1, request-grant to r_valid latency in cycles, legal 1..4
STALL_THRESH, 0, 8-bit threshold; a port stalls when lfsr[7:0] < STALL_THRESH (0 = never stall)
LFSR_SEED, 16'hACE1, base seed; port p uses LFSR_SEED ^ p, forced to 16'h0001 if the result is 0
EOC_ADDR, 32'h80000000, mailbox byte address

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
tcdm_req_i  in  NP  request per port
tcdm_gnt_o  out  NP  grant, combinational
tcdm_add_i  in  NPx32  byte address
tcdm_wen_i  in  NP  1 = read, 0 = write
tcdm_be_i  in  NPx4  byte enables
tcdm_data_i  in  NPx32  write data
tcdm_r_data_o  out  NPx32  read data
tcdm_r_valid_o  out  NP  response valid
stall_en_i  in  1  global enable for stall injection
clear_cnt_i  in  1  synchronous counter clear
eoc_o  out  1  sticky EOC flag
eoc_data_o  out  32  data of the first EOC write
cnt_rd_o  out  NPx32  granted reads per port
cnt_wr_o  out  NPx32  granted writes per port
oor_cnt_o  out  16  out-of-range accesses, saturating

Behaviour:
Reset:
- All outputs 0; r_valid pipeline flushed; LFSRs reseeded; counters and eoc cleared.
- Memory contents retained, so bench preload survives a mid-run reset.
- Requests sampled during reset are not granted.

Per-port LFSRs:
- 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift every cycle out of reset.
- stall[p] = stall_en_i & (lfsr[p][7:0] < STALL_THRESH).

Addressing:
- widx = (add - BASE_ADDR) >> 2; add[1:0] ignored.
- In range iff BASE_ADDR <= add < BASE_ADDR + 4*MEM_WORDS.

Conflicts (same cycle, same widx):
- Two or more writers: the lowest-index unstalled writer is granted; the others see gnt=0 and must hold their request.
- Reads never lose: simultaneous read and write to the same word are both granted, and the read returns the pre-write data.

Grant:
- gnt[p] = req[p] & ~rst_i & ~stall[p] & ~lost[p].
- A request may be held across stalls. The block tolerates add/data changing while gnt=0.

Granted read:
- Data sampled in the grant cycle.
- r_valid[p] = 1 with r_data exactly RLAT cycles later, single-cycle pulse.
- Back-to-back grants give back-to-back responses (RLAT-deep shift pipeline per port, fully pipelined).

Granted write:
- Bytes with be[i]=1 updated at the grant-cycle clock edge; be=4'b0000 leaves the word unchanged but still counts.
- r_valid pulses RLAT cycles later with r_data = 0.

Out of range (not EOC_ADDR):
- Always granted unless stalled.
- Read returns 32'hDEADBEEF; write dropped.
- oor_cnt_o increments, saturating at 16'hFFFF.

EOC:
- A granted write with add == EOC_ADDR is not stored and is not counted as out of range.
- eoc_o rises the next cycle and stays high until reset.
- eoc_data_o latches the first EOC write only. If several ports write EOC in the same cycle, the lowest index wins.
- A read of EOC_ADDR returns {31'b0, eoc_o}.

Counters:
- cnt_rd/cnt_wr increment on granted reads/writes, EOC included; saturate at 32'hFFFFFFFF.
- clear_cnt_i zeroes cnt_rd, cnt_wr and oor_cnt next cycle; clear wins over a same-cycle increment.

Assertions (simulation):
- RLAT outside 1..4 is fatal at elaboration.
- A port with req=1, gnt=0 that drops req or changes add/wen/data before grant is flagged as a protocol warning.

Test Plan:
- RLAT=1, STALL_THRESH=0: port 0 writes 32'h12345678 to 32'h1c010010 with be=4'b0011, then reads it → gnt the same cycle, r_valid 1 cycle after each grant, read data 32'h00005678 over a zero preload; cnt_wr[0]=1, cnt_rd[0]=1.
- RLAT=3: port 2 issues 4 back-to-back reads of preloaded words 0..3 → r_valid high on cycles 3..6 after the first grant, data in order, no gaps.
- Ports 1 and 4 both write to 32'h1c010020 (data 32'hAAAA0001 and 32'hBBBB0004) while port 5 reads the same word (old value 32'h0) → only port 1 and port 5 granted; port 5 gets 32'h0; next cycle port 4 is granted; final word 32'hBBBB0004.
- STALL_THRESH=128, stall_en_i=1, 1000 held read requests on port 0 → every request eventually granted; gnt sequence identical across two runs with the same seed; stall_en_i=0 gives 100% grant.
- Write 32'h1 to 32'h80000000 from ports 3 and 6 in the same cycle, then port 6 writes 32'h2 → eoc_o=1 next cycle, eoc_data_o=32'h1, memory unchanged, oor_cnt_o=0.
- Read 32'h00000100 (out of range) → r_data 32'hDEADBEEF, oor_cnt_o=1. Then assert rst_i for 2 cycles while an RLAT=2 read is in flight → no r_valid emitted, counters and eoc are 0, preloaded word 0 still intact.
